bcd_countdown_timer: RTL and testbench

Parametrised next-generation egg-timer core: debounced set buttons, a programmable BCD mm:ss value, start/pause/resume, and a timed alarm on expiry.
It replaces the fixed timer path under top, feeding the seven-segment driver with four BCD digits.
Tick rate, debounce length, minute limit and alarm duration are parameters, so one RTL serves simulation and the board.

---
 rtl/timer_pkg.sv | 73 +++++++
 rtl/button_debounce.sv | 60 ++++++
 rtl/bcd_countdown_timer.sv | 153 +++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer.
//   state_e        : controller states, encoded as seen on the state output
//   bcd2_t/mmss_t  : two-digit BCD field and a full mm:ss value
//   bcd_inc_wrap   : increment a two-digit BCD field, wrapping to 00 past a limit
//   bcd_dec_mmss   : subtract one second from mm:ss with a digit-by-digit borrow
//   mmss_is_zero   : true at 00:00
package timer_pkg;

    localparam int         BCD_W        = 4;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd2_t;

    typedef struct packed {
        bcd2_t mm;
        bcd2_t ss;
    } mmss_t;

    function automatic bcd2_t bcd_inc_wrap(input bcd2_t v, input int max_val);
        bcd2_t r;
        int    cur;
        cur = int'(v.tens) * 10 + int'(v.ones);
        if (cur >= max_val) begin
            r = '0;
        end else if (v.ones == 4'd9) begin
            r.tens = v.tens + 4'd1;
            r.ones = 4'd0;
        end else begin
            r.tens = v.tens;
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    // Only called with a nonzero value; 00:00 never reaches the borrow chain.
    function automatic mmss_t bcd_dec_mmss(input mmss_t t);
        mmss_t r;
        r = t;
        if (t.ss.ones != 4'd0) begin
            r.ss.ones = t.ss.ones - 4'd1;
        end else begin
            r.ss.ones = 4'd9;
            if (t.ss.tens != 4'd0) begin
                r.ss.tens = t.ss.tens - 4'd1;
            end else begin
                r.ss.tens = SEC_TENS_MAX;
                if (t.mm.ones != 4'd0) begin
                    r.mm.ones = t.mm.ones - 4'd1;
                end else begin
                    r.mm.ones = 4'd9;
                    r.mm.tens = t.mm.tens - 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic mmss_is_zero(input mmss_t t);
        return (t == '0);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioning: 2-FF synchroniser, level debouncer and rising-edge pulse.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   din    : raw asynchronous button level
//   level  : debounced level, changes after DEBOUNCE_CYCLES stable cycles
//   pulse  : one-cycle pulse on each accepted 0->1 transition of level
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic pulse
);

    localparam int            CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Down-counter reloads whenever the input agrees with the accepted level,
    // so reaching zero means DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            level_d = sync2_q;
            cnt_d   = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
        pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= RELOAD;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Egg-timer core: settable BCD mm:ss, start/pause/resume, alarm on expiry.
//   clk, reset          : system clock, asynchronous active-low reset
//   cook_time           : raw level, 1 requests set mode
//   minutes_up/seconds_up/start : raw push-buttons
//   debounce_min/sec    : debounced button levels
//   minute_*/second_*   : BCD digits of the current value
//   running, alarm      : 1 in RUN, 1 in DONE
//   state               : current controller state
//
// state | meaning
// IDLE  | waiting; cook_time enters SET, start runs a nonzero value
// SET   | buttons increment minutes/seconds
// RUN   | prescaler ticks, value counts down once per tick
// PAUSE | value and prescaler frozen
// DONE  | alarm high at 00:00 until acknowledge or timeout
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV        = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_MINUTES     = 99,
    parameter int ALARM_SECS      = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cook_time,
    input  logic             minutes_up,
    input  logic             seconds_up,
    input  logic             start,
    output logic             debounce_min,
    output logic             debounce_sec,
    output logic [BCD_W-1:0] minute_tens,
    output logic [BCD_W-1:0] minute_ones,
    output logic [BCD_W-1:0] second_tens,
    output logic [BCD_W-1:0] second_ones,
    output logic             running,
    output logic             alarm,
    output logic [2:0]       state
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam int            AW         = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [AW-1:0] ALARM_LAST = AW'((ALARM_SECS > 0) ? ALARM_SECS - 1 : 0);

    logic min_p, sec_p, start_p, start_level_unused;
    logic cook_s1_q, cook_s2_q, cook_prev_q;

    state_e        state_q, state_d;
    mmss_t         time_q, time_d, time_dec;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic          tick, timeout, cook_rise, ack;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_min (
        .clk(clk), .rst_n(reset), .din(minutes_up), .level(debounce_min), .pulse(min_p)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sec (
        .clk(clk), .rst_n(reset), .din(seconds_up), .level(debounce_sec), .pulse(sec_p)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk(clk), .rst_n(reset), .din(start), .level(start_level_unused), .pulse(start_p)
    );

    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        presc_d     = presc_q;
        alarm_cnt_d = alarm_cnt_q;
        time_dec    = bcd_dec_mmss(time_q);
        tick        = (presc_q == PRESC_LAST);
        timeout     = (ALARM_SECS > 0) && tick && (alarm_cnt_q == ALARM_LAST);
        cook_rise   = cook_s2_q & ~cook_prev_q;
        ack         = start_p | min_p | sec_p | cook_rise;

        case (state_q)
            ST_IDLE: begin
                presc_d     = '0;
                alarm_cnt_d = '0;
                if (cook_s2_q) begin
                    state_d = ST_SET;
                end else if (start_p && !mmss_is_zero(time_q)) begin
                    state_d = ST_RUN;
                end
            end
            ST_SET: begin
                presc_d = '0;
                if (min_p) time_d.mm = bcd_inc_wrap(time_q.mm, MAX_MINUTES);
                if (sec_p) time_d.ss = bcd_inc_wrap(time_q.ss, 59);
                if (!cook_s2_q) begin
                    state_d = ST_IDLE;
                end else if (start_p && !mmss_is_zero(time_q)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                alarm_cnt_d = '0;
                presc_d     = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    time_d = time_dec;
                    // The expiring tick swallows a coincident start press.
                    if (mmss_is_zero(time_dec)) begin
                        state_d = ST_DONE;
                    end else if (start_p) begin
                        state_d = ST_PAUSE;
                    end
                end else if (start_p) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (start_p) state_d = ST_RUN;
            end
            ST_DONE: begin
                if (ALARM_SECS > 0) begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) alarm_cnt_d = alarm_cnt_q + 1'b1;
                end
                if (ack || timeout) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cook_s1_q   <= 1'b0;
            cook_s2_q   <= 1'b0;
            cook_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            time_q      <= '0;
            presc_q     <= '0;
            alarm_cnt_q <= '0;
        end else begin
            cook_s1_q   <= cook_time;
            cook_s2_q   <= cook_s1_q;
            cook_prev_q <= cook_s2_q;
            state_q     <= state_d;
            time_q      <= time_d;
            presc_q     <= presc_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    assign minute_tens = time_q.mm.tens;
    assign minute_ones = time_q.mm.ones;
    assign second_tens = time_q.ss.tens;
    assign second_ones = time_q.ss.ones;
    assign running     = (state_q == ST_RUN);
    assign alarm       = (state_q == ST_DONE);
    assign state       = state_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer with small parameters.
module tb_bcd_countdown_timer;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;
    localparam int MAXM     = 12;
    localparam int ALS      = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cook_time = 1'b0, minutes_up = 1'b0, seconds_up = 1'b0, start = 1'b0;
    logic       debounce_min, debounce_sec, running, alarm;
    logic [3:0] minute_tens, minute_ones, second_tens, second_ones;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int m_min = 0;
    int m_sec = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(
        .TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB), .MAX_MINUTES(MAXM), .ALARM_SECS(ALS)
    ) dut (
        .clk(clk), .reset(reset), .cook_time(cook_time), .minutes_up(minutes_up),
        .seconds_up(seconds_up), .start(start), .debounce_min(debounce_min),
        .debounce_sec(debounce_sec), .minute_tens(minute_tens), .minute_ones(minute_ones),
        .second_tens(second_tens), .second_ones(second_ones), .running(running),
        .alarm(alarm), .state(state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int mm, input int ss);
        chk(tag, {16'd0, minute_tens, minute_ones, second_tens, second_ones}, {16'd0, to_bcd(mm, ss)});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: bit0 minutes_up, bit1 seconds_up, bit2 start
    task automatic press(input logic [2:0] which);
        minutes_up = which[0];
        seconds_up = which[1];
        start      = which[2];
        cyc(8);
        minutes_up = 1'b0;
        seconds_up = 1'b0;
        start      = 1'b0;
        cyc(8);
    endtask

    task automatic set_press(input logic [2:0] which);
        press(which);
        if (which[0]) m_min = (m_min + 1) % (MAXM + 1);
        if (which[1]) m_sec = (m_sec + 1) % 60;
    endtask

    task automatic load(input int mm, input int ss);
        repeat ((mm - m_min + MAXM + 1) % (MAXM + 1)) set_press(3'b001);
        repeat ((ss - m_sec + 60) % 60) set_press(3'b010);
    endtask

    task automatic enter_set();
        cook_time = 1'b1;
        cyc(4);
        chk("enter_set", state, 1);
    endtask

    task automatic leave_set();
        cook_time = 1'b0;
        cyc(4);
        chk("leave_set", state, 0);
    endtask

    task automatic start_run(input string tag);
        logic found;
        found = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state == 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk(tag, found, 1);
    endtask

    initial begin
        int   rem0, rem, run_cnt, rises;
        logic prev, done_seen;

        // power-up reset
        cyc(3);
        chk("rst_state", state, 0);
        chk_time("rst_time", 0, 0);
        chk("rst_running", running, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_dbmin", debounce_min, 0);
        chk("rst_dbsec", debounce_sec, 0);
        reset = 1'b1;
        cyc(2);

        // asynchronous reset in the middle of a countdown
        enter_set();
        load(5, 37);
        chk_time("load_0537", 5, 37);
        leave_set();
        start_run("run_0537");
        cyc(10);
        chk("run_0537_running", running, 1);
        #2;
        reset = 1'b0;
        #1;
        chk_time("async_rst_time", 0, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_alarm", alarm, 0);
        chk("async_rst_running", running, 0);
        @(negedge clk);
        reset = 1'b1;
        m_min = 0;
        m_sec = 0;
        cyc(2);
        press(3'b100);
        chk("start_at_zero_ignored", state, 0);
        chk_time("start_at_zero_time", 0, 0);

        // bouncing minutes button yields a single accepted press
        enter_set();
        rises = 0;
        prev  = debounce_min;
        for (int c = 0; c < 40; c++) begin
            if (c < 20)      minutes_up = ((c / 2) % 2 == 0);
            else if (c < 30) minutes_up = 1'b1;
            else             minutes_up = 1'b0;
            @(negedge clk);
            if (debounce_min && !prev) rises++;
            prev = debounce_min;
            if (c == 19) chk("bounce_rejected", debounce_min, 0);
            if (c == 29) chk("bounce_level_high", debounce_min, 1);
        end
        m_min = 1;
        chk("bounce_rises", rises, 1);
        chk("bounce_level_low", debounce_min, 0);
        chk_time("bounce_time", 1, 0);

        // minute and second wrap in SET
        repeat (11) set_press(3'b001);
        chk_time("min_max", MAXM, 0);
        set_press(3'b001);
        chk_time("min_wrap", 0, 0);
        set_press(3'b001);
        repeat (59) set_press(3'b010);
        chk_time("sec_59", 1, 59);
        set_press(3'b010);
        chk_time("sec_wrap_no_carry", 1, 0);
        set_press(3'b011);
        chk_time("both_buttons", 2, 1);

        // random press mixes against the model
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(3, 10));
            for (int k = 0; k < n; k++) set_press(3'($urandom_range(1, 3)));
            chk_time("rand_set", m_min, m_sec);
        end

        // 01:00 countdown to expiry
        load(1, 0);
        chk_time("load_0100", 1, 0);
        leave_set();
        chk_time("idle_keeps_value", 1, 0);
        rem0 = m_min * 60 + m_sec;
        start_run("run_0100");
        cyc(3);
        chk_time("run_pre_tick", rem0 / 60, rem0 % 60);
        cyc(1);
        chk_time("run_first_tick", (rem0 - 1) / 60, (rem0 - 1) % 60);
        cyc(235);
        chk_time("run_last_second", 0, 1);
        chk("run_last_state", state, 2);
        cyc(1);
        chk_time("run_expired", 0, 0);
        chk("done_state", state, 4);
        chk("done_alarm", alarm, 1);
        chk("done_running", running, 0);
        m_min = 0;
        m_sec = 0;

        // alarm auto-clears after ALARM_SECS ticks
        cyc(ALS * TICK_DIV - 1);
        chk("done_hold", state, 4);
        cyc(1);
        chk("done_timeout_state", state, 0);
        chk("done_timeout_alarm", alarm, 0);

        // pause keeps the partial second
        enter_set();
        load(0, 5);
        leave_set();
        start_run("run_0005");
        run_cnt   = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (state == 3'd2) run_cnt++;
            else if (state == 3'd4) begin
                done_seen = 1'b1;
                break;
            end
            if (i == 100) chk("paused_state", state, 3);
            if (i == 9)   start = 1'b1;
            if (i == 19)  start = 1'b0;
            if (i == 115) start = 1'b1;
            if (i == 125) start = 1'b0;
            @(negedge clk);
            rem = 5 - run_cnt / TICK_DIV;
            if (rem < 0) rem = 0;
            chk_time("pause_track", rem / 60, rem % 60);
        end
        start = 1'b0;
        chk("pause_reached_done", done_seen, 1);
        chk("pause_run_clks", run_cnt, 5 * TICK_DIV);

        // seconds press acknowledges the alarm before the timeout
        seconds_up = 1'b1;
        cyc(5);
        chk("ack_pending_state", state, 4);
        chk("ack_pending_alarm", alarm, 1);
        cyc(1);
        chk("ack_state", state, 0);
        chk("ack_alarm", alarm, 0);
        chk_time("ack_time", 0, 0);
        seconds_up = 1'b0;
        cyc(10);
        chk("ack_stays_idle", state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
